// File: rtl/signed_div_seq.sv
// signed_div_seq: sequential signed 2W/W restoring divider (clk, rst, start, dividend, divisor -> busy, done, quo, rem, ovf, dz)
module signed_div_seq #(
  parameter int W = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [2*W-1:0] dividend,
  input  logic [W-1:0]   divisor,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   quo,
  output logic [W-1:0]   rem,
  output logic           ovf,
  output logic           dz
);
  localparam int cw = $clog2(W + 1);
  localparam logic [W-1:0] min_mag = {1'b1, {(W-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, CHECK, DIVIDE, FIX, DONE} state_t;
  state_t state;
  logic [2*W-1:0] dvd, mag_a;
  logic [W-1:0] dvs, mag_b, r, q, diff;
  logic [W:0] trial;
  logic [cw-1:0] cnt;
  logic sign_a, sign_b, ge, neg, fix_ovf;
  always_comb begin
    mag_a = dvd[2*W-1] ? -dvd : dvd;
    mag_b = dvs[W-1] ? -dvs : dvs;
    trial = {r, q[W-1]};
    diff = trial[W-1:0] - dvs;
    ge = trial >= {1'b0, dvs};
    neg = sign_a ^ sign_b;
    fix_ovf = neg ? q > min_mag : q >= min_mag;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      quo <= '0;
      rem <= '0;
      ovf <= 1'b0;
      dz <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          dvd <= dividend;
          dvs <= divisor;
          sign_a <= dividend[2*W-1];
          sign_b <= divisor[W-1];
          busy <= 1'b1;
          quo <= '0;
          rem <= '0;
          ovf <= 1'b0;
          dz <= 1'b0;
          state <= CHECK;
        end
        CHECK: begin
          r <= mag_a[2*W-1:W];
          q <= mag_a[W-1:0];
          dvs <= mag_b;
          cnt <= cw'(W);
          if (dvs == '0) begin
            dz <= 1'b1;
            ovf <= 1'b1;
            done <= 1'b1;
            state <= DONE;
          end else if (mag_a[2*W-1:W] >= mag_b) begin
            ovf <= 1'b1;
            done <= 1'b1;
            state <= DONE;
          end else begin
            state <= DIVIDE;
          end
        end
        DIVIDE: begin
          r <= ge ? diff : trial[W-1:0];
          q <= {q[W-2:0], ge};
          cnt <= cnt - 1'b1;
          if (cnt == cw'(1)) state <= FIX;
        end
        FIX: begin
          ovf <= fix_ovf;
          quo <= fix_ovf ? '0 : (neg ? -q : q);
          rem <= fix_ovf ? '0 : (sign_a ? -r : r);
          done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/signed_div_seq.md
SIGNED_DIV_SEQ -- requirements
Module: signed_div_seq

Interface
REQ-001 SHALL have parameter W, default 8, giving the operand width; legal W >= 4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request a division; sampled only while busy=0.
REQ-005 SHALL have port dividend, input, 2W bits: two's-complement dividend, captured on the accepted start edge.
REQ-006 SHALL have port divisor, input, W bits: two's-complement divisor, captured on the accepted start edge.
REQ-007 SHALL have port busy, output, 1 bit: high from the accepted start edge until done deasserts.
REQ-008 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL have port quo, output, W bits: signed quotient, truncated toward zero.
REQ-010 SHALL have port rem, output, W bits: signed remainder; sign equals dividend sign, or zero.
REQ-011 SHALL have port ovf, output, 1 bit: quotient not representable in W signed bits, or divide by zero.
REQ-012 SHALL have port dz, output, 1 bit: divisor was zero.

Function
REQ-013 SHALL implement FSM states IDLE, CHECK, DIVIDE, FIX, DONE.
REQ-014 SHALL, in IDLE with start=1, capture operands, store both sign bits, and go to CHECK; busy rises on that edge.
REQ-015 SHALL, in CHECK, form magnitudes |dividend| (2W-bit unsigned) and |divisor| (W-bit unsigned).
REQ-016 SHALL, in CHECK, go to DONE with dz=1, ovf=1, quo=0, rem=0 when divisor=0.
REQ-017 SHALL, in CHECK, go to DONE with ovf=1, dz=0, quo=0, rem=0 when the upper W bits of |dividend| >= |divisor|.
REQ-018 SHALL otherwise go to DIVIDE with an iteration counter of W.
REQ-019 SHALL, in DIVIDE, perform one restoring shift-subtract step per cycle for exactly W cycles, then go to FIX.
REQ-020 SHALL, in FIX, set ovf=1 and quo=rem=0 when the result sign is negative (operand signs differ) and the magnitude quotient > 2^(W-1).
REQ-021 SHALL, in FIX, set ovf=1 and quo=rem=0 when the result sign is positive and the magnitude quotient > 2^(W-1)-1.
REQ-022 SHALL, in FIX when no overflow, negate the quotient when the signs differ and negate the remainder when the dividend is negative.
REQ-023 SHALL, in FIX, register the result and go to DONE.
REQ-024 SHALL, in DONE, drive done=1 for exactly one cycle, then go to IDLE; busy deasserts on the same edge done deasserts.
REQ-025 SHALL give normal-path latency: done high in the cycle after edge k+W+2, where edge k accepted start.
REQ-026 SHALL give error-path latency: done high in the cycle after edge k+1.
REQ-027 SHALL hold quo, rem, ovf and dz stable from done until the next accepted start, then clear them to 0 on that start edge.
REQ-028 SHALL ignore start while busy=1, leaving captured operands and the FSM unaffected.
REQ-029 SHALL accept start in the cycle after done, since the FSM is then in IDLE.
REQ-030 SHALL produce a correct result for the most negative dividend (-2^(2W-1)) and the most negative divisor (-2^(W-1)), with no internal overflow in the magnitude logic.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, go to IDLE and set busy=0, done=0, quo=0, rem=0, ovf=0, dz=0.
REQ-032 SHALL let rst take priority over start and abort any division in progress, producing no done pulse for it.

Verification
REQ-033 SHALL cover, with W=8: dividend=100, divisor=7 -> quo=14, rem=2, ovf=0; done in the cycle after edge k+10.
REQ-034 SHALL cover signs: -100/7 -> quo=-14 (0xF2), rem=-2 (0xFE); 100/-7 -> quo=-14, rem=2; -100/-7 -> quo=14, rem=-2.
REQ-035 SHALL cover overflow: 1000/3 -> ovf=1, quo=0, rem=0; 128/1 -> ovf=1; -128/1 -> quo=0x80, ovf=0; -32768/-128 -> ovf=1 via CHECK.
REQ-036 SHALL cover divide by zero: 55/0 -> dz=1, ovf=1, quo=0, rem=0; done in the cycle after edge k+1.
REQ-037 SHALL cover start pulsed mid-DIVIDE with other operands -> ignored, and the original result is returned.
REQ-038 SHALL cover rst asserted mid-DIVIDE -> all outputs 0, no done; a following start of 100/7 completes correctly.
